// File: rtl/uart_pkg.sv
// Shared definitions for the UART library counters.
//   COUNTER_W_DEFAULT : default counter/modulus width
//   DIR_UP / DIR_DOWN : encodings of the 'up' direction input
//   MODE_WRAP / MODE_ONESHOT : encodings of the 'oneshot' mode input
package uart_pkg;
  localparam int unsigned COUNTER_W_DEFAULT = 8;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/mod_counter_prog.sv
// Programmable modulo counter (baud divider, bit counter, timeout timer).
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high
//   ce       : count enable, one step per cycle
//   clr      : sync clear (q to start value for direction, done cleared)
//   load     : sync load of load_val into q
//   load_val : load data (W bits)
//   mod_wr   : write modulus register with mod_val
//   mod_val  : new modulus, 0 selects 2^W
//   up       : 1 count up, 0 count down
//   oneshot  : 1 stop at terminal, 0 wrap
//   q        : current count (registered)
//   at_term  : q is at the terminal value for the current direction
//   wrap     : one-cycle registered pulse after a terminal step
//   done     : sticky, one-shot run reached terminal
module mod_counter_prog
  import uart_pkg::*;
#(
  parameter int unsigned W         = COUNTER_W_DEFAULT,
  parameter int unsigned N_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         mod_wr,
  input  logic [W-1:0] mod_val,
  input  logic         up,
  input  logic         oneshot,
  output logic [W-1:0] q,
  output logic         at_term,
  output logic         wrap,
  output logic         done
);

  localparam logic [W-1:0] MOD_INIT = W'(N_DEFAULT);

  logic [W-1:0] q_reg, q_d;
  logic [W-1:0] mod_reg, mod_d;
  logic         wrap_reg, wrap_d;
  logic         done_reg, done_d;
  logic [W-1:0] limit;
  logic         term;

  // mod_reg = 0 wraps to all-ones, giving the full 2^W range.
  assign limit = mod_reg - W'(1);

  // Up terminal also covers q beyond a shrunk modulus so the counter recovers
  // in a single step.
  always_comb begin
    term = 1'b0;
    if (up == DIR_UP) term = (q_reg >= limit);
    else              term = (q_reg == '0);
  end

  always_comb begin
    q_d    = q_reg;
    mod_d  = mod_reg;
    done_d = done_reg;
    wrap_d = 1'b0;

    // Modulus write is outside the priority chain; the step below still sees
    // the old limit because it reads mod_reg, not mod_d.
    if (mod_wr) mod_d = mod_val;

    if (clr) begin
      q_d    = (up == DIR_UP) ? '0 : limit;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = load_val;
      done_d = 1'b0;
    end else if (ce && !done_reg) begin
      if (!term) begin
        q_d = (up == DIR_UP) ? q_reg + W'(1) : q_reg - W'(1);
      end else if (oneshot == MODE_WRAP) begin
        q_d    = (up == DIR_UP) ? '0 : limit;
        wrap_d = 1'b1;
      end else begin
        // done_reg was low to get here, so this is the first terminal hit.
        done_d = 1'b1;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= '0;
      mod_reg  <= MOD_INIT;
      wrap_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_d;
      mod_reg  <= mod_d;
      wrap_reg <= wrap_d;
      done_reg <= done_d;
    end
  end

  assign q       = q_reg;
  assign at_term = term;
  assign wrap    = wrap_reg;
  assign done    = done_reg;

endmodule
